display_scanner: RTL
====================

Name: display_scanner

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto a single 7-segment decoder stage. The block sits directly upstream of the decoder.
- Per digit slot it drives one 4-bit BCD nibble on `digit` (to the decoder data input) and one active-low common-anode select.
- New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 1..8.
- PRESCALE, 50000: clock cycles each digit stays lit; legal range 1..2^20.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures digits_in into the pending buffer.
- digits_in  input  4*NUM_DIGITS  BCD digits; nibble i (bits 4i+3:4i) is digit i, with digit 0 the least significant (rightmost).
- digit  output  4  BCD nibble of the currently lit digit; feeds the decoder data input.
- anode  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
- frame_start  output  1  one-cycle pulse marking the cycle in which digit 0 becomes lit.

Behaviour:
- Registers:
  - pending[NUM_DIGITS] and pending_valid.
  - active[NUM_DIGITS].
  - prescaler, width clog2(PRESCALE) (minimum 1).
  - index, width clog2(NUM_DIGITS) (minimum 1).
  - All outputs are registered.
- Reset (synchronous, takes priority over all other inputs, including mid-frame and mid-load):
  - pending, active = 0; pending_valid = 0.
  - prescaler = 0; index = NUM_DIGITS-1.
  - digit = 0; anode = all ones (blank); frame_start = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1). With PRESCALE=1, tick is asserted every cycle.
- Scan, on a tick edge:
  - index <= (index == NUM_DIGITS-1) ? 0 : index+1.
  - digit and anode update on that same edge to reflect the new index; each digit is lit for exactly PRESCALE cycles.
  - First tick after reset: index wraps to 0. Digit 0 lights on the edge at cycle PRESCALE after reset deassertion, with frame_start pulsed.
- Commit, on a tick edge where index wraps to 0:
  - If pending_valid, then active <= pending and pending_valid <= 0.
  - The digit and anode values driven on that edge already use the newly committed data.
  - frame_start <= 1 on that edge; it is 0 at all other times.
- Load:
  - When load=1: pending <= digits_in and pending_valid <= 1.
  - Repeated loads before a commit: last one wins.
  - Load in the same cycle as a commit: the previously pending value commits now. The newly loaded value is held and commits at the next frame boundary.
- Digit output rule for the lit slot i with value v = active[i]:
  - If v <= 9: digit = v and anode[i] = 0; all other anode bits = 1.
  - If v >= 10 (invalid BCD): digit = 0 and anode = all ones (slot blanked). The decoder never receives a non-BCD code.
- NUM_DIGITS=1:
  - index stays at 0.
  - Every tick is a frame boundary: commit opportunity and frame_start pulse on every tick.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DISPLAY_SCANNER_LZB_EN (leading-zero blanking).
- Defined:
  - Slot i > 0 is blanked (anode all ones, digit = 0) when active[j] == 0 for every j >= i.
  - Slot 0 is never blanked by this rule, so value 0 shows a single "0".
  - Blanking is evaluated on the active buffer only.
- Undefined:
  - All valid digits are lit, including leading zeros.
  - The invalid-BCD blanking rule applies in both builds.

Test Plan (NUM_DIGITS=4, PRESCALE=4 unless noted):
- Reset then idle:
  - anode=4'b1111 and digit=0 for cycles 0-3.
  - At cycle 4: anode=4'b1110, digit=0, frame_start=1 for one cycle.
  - Slots then advance every 4 cycles: 1101, 1011, 0111, 1110.
- Mid-frame load of 16'h1234 while slot 1 is lit:
  - Slots 1-3 in the current frame still show 0.
  - At the next frame_start: digit sequence 4,3,2,1 with anodes 1110,1101,1011,0111.
- Load 16'h5678, then 16'h9012 before the boundary: the frame shows 2,1,0,9 (last wins).
- Load 16'h1111 coinciding with a commit edge that holds pending 16'h2222:
  - The current frame shows all 2s.
  - The next frame shows all 1s.
- Load 16'h00A7:
  - Slot 1 (value A) is blanked: anode=1111 and digit=0 for its 4 cycles.
  - Slot 0 shows 7.
  - With DISPLAY_SCANNER_LZB_EN, slots 2-3 are also blank; without it, they show 0.
- Assert reset while slot 2 is lit:
  - The next cycle shows anode=1111, digit=0, and pending/active cleared.
  - Digit 0 re-lights at cycle 4 after reset deassertion.
  - Also run PRESCALE=1: the slot changes every cycle.

Source files
------------

// File: rtl/display_scanner.sv
// Time-multiplexed BCD digit scanner feeding a single 7-segment decoder; new digits commit only at frame boundaries.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCANNER_LZB_EN.
module display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PRESCALE - 1);

    logic [3:0]            pending_reg [NUM_DIGITS];
    logic                  pending_valid_reg;
    logic [3:0]            active_reg  [NUM_DIGITS];
    logic [3:0]            active_next [NUM_DIGITS];
    logic [PS_W-1:0]       prescaler_reg;
    logic [IDX_W-1:0]      index_reg;
    logic [IDX_W-1:0]      index_next;
    logic [3:0]            digit_reg;
    logic [3:0]            digit_next;
    logic [NUM_DIGITS-1:0] anode_reg;
    logic [NUM_DIGITS-1:0] anode_next;
    logic                  frame_start_reg;

    logic                  tick;
    logic                  wrap;
    logic                  commit;
    logic [NUM_DIGITS-1:0] slot_sel;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            slot_val;
    logic                  slot_blank;
    logic                  show;

    assign tick       = (prescaler_reg == LAST_PS);
    assign wrap       = (index_reg == LAST_IDX);
    assign index_next = wrap ? '0 : index_reg + 1'b1;
    assign commit     = tick && wrap && pending_valid_reg;

    // Outputs on a tick are computed from the buffer as it will be after this edge,
    // so the first slot of a new frame already shows freshly committed data.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign active_next[gi] = commit ? pending_reg[gi] : active_reg[gi];
            assign slot_sel[gi]    = (index_next == IDX_W'(gi));
        end
    endgenerate

`ifdef DISPLAY_SCANNER_LZB_EN
    logic [NUM_DIGITS-1:0] nonzero;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            assign nonzero[gi] = |active_next[gi];
            if (gi == 0) begin : g_units
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = ~|nonzero[NUM_DIGITS-1:gi];
            end
        end
    endgenerate
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        slot_val   = 4'd0;
        slot_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_sel[i]) begin
                slot_val   = active_next[i];
                slot_blank = lz_blank[i];
            end
        end
        // Non-BCD codes never reach the decoder; the slot goes dark instead.
        show       = (slot_val <= 4'd9) && !slot_blank;
        digit_next = show ? slot_val : 4'd0;
        anode_next = show ? ~slot_sel : '1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pending_reg[i] <= 4'd0;
                active_reg[i]  <= 4'd0;
            end
            pending_valid_reg <= 1'b0;
            prescaler_reg     <= '0;
            index_reg         <= LAST_IDX;
            digit_reg         <= 4'd0;
            anode_reg         <= '1;
            frame_start_reg   <= 1'b0;
        end else begin
            prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;

            // A load on a commit edge survives: the old pending value commits, the new one waits.
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    pending_reg[i] <= digits_in[4*i +: 4];
                end
                pending_valid_reg <= 1'b1;
            end else if (commit) begin
                pending_valid_reg <= 1'b0;
            end

            if (tick) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active_reg[i] <= active_next[i];
                end
                index_reg       <= index_next;
                digit_reg       <= digit_next;
                anode_reg       <= anode_next;
                frame_start_reg <= wrap;
            end else begin
                frame_start_reg <= 1'b0;
            end
        end
    end

    assign digit       = digit_reg;
    assign anode       = anode_reg;
    assign frame_start = frame_start_reg;

endmodule
